// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port memory between the fetch stage (IF)
// and the memory stage (DM). Each access runs IDLE -> ACCESS -> WAIT -> RESP with
// a fixed memory latency. Read data and ready pulses are registered. A
// combinational stall line freezes the pipeline while a request is outstanding.
module pipe_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 1,   // 1..15
  parameter int MAX_DM_STREAK = 2    // 1..7
) (
  input  logic                clk,
  input  logic                rst,        // asynchronous, active low
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  localparam int BE_W     = DATA_W / 8;
  localparam int LAT_W    = 4;   // holds MEM_LAT up to 15
  localparam int STREAK_W = 3;   // holds MAX_DM_STREAK up to 7

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  logic [1:0]          state;
  logic                owner_dm;    // 1 = current access belongs to DM
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STREAK_W-1:0] streak;

  // DM is older in program order and normally wins. A fetch that has lost
  // MAX_DM_STREAK grants in a row is let through so it cannot starve.
  logic grant_dm;
  logic last_wait;

  assign grant_dm  = dm_req & (~if_req | (streak != STREAK_MAX));
  assign last_wait = (state == S_WAIT) && (lat_cnt == LAT_W'(1));

  // Sequence control: state, owner, latency counter and starvation streak.
  // NOTE: all sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would let one register see another's new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      owner_dm <= 1'b0;
      lat_cnt  <= '0;
      streak   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_req || dm_req) begin
            owner_dm <= grant_dm;
            state    <= S_ACCESS;
            if (grant_dm && if_req)
              streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
              streak <= '0;
          end
        end
        S_ACCESS: begin
          lat_cnt <= LAT_LOAD;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (last_wait) state <= S_RESP;
        end
        default: state <= S_IDLE;   // RESP: requests are not re-sampled here
      endcase
    end
  end

  // Capture the winning request's address, direction and payload at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (state == S_IDLE && (if_req || dm_req)) begin
      if (grant_dm) begin
        lat_addr  <= dm_addr;
        lat_we    <= dm_we;
        lat_wdata <= dm_wdata;
        lat_be    <= dm_be;
      end else begin
        lat_addr  <= if_addr;
        lat_we    <= 1'b0;
        lat_wdata <= '0;
        lat_be    <= '1;          // fetches always read the full word
      end
    end
  end

  // Sample read data on the last WAIT cycle and raise the owner's ready for
  // exactly the RESP cycle. Writes pulse ready but leave rdata untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      dm_rdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
    end else begin
      if_ready <= last_wait & ~owner_dm;
      dm_ready <= last_wait &  owner_dm;
      if (last_wait && !lat_we) begin
        if (owner_dm) dm_rdata <= mem_rdata;
        else          if_rdata <= mem_rdata;
      end
    end
  end

  // Memory side: only mem_en qualifies the bus, which holds its last value.
  assign mem_en    = (state == S_ACCESS);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_be    = lat_be;

  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule
